cpp_internal_double_to_bool_hyst_array: RTL and testbench
=========================================================

// Module: cpp_internal_double_to_bool_hyst_array
// PURPOSE
//  Multi-channel IEEE-754 double -> bool converter with per-channel hysteresis
//  and debounce, clocked; successor of the single-channel double-to-bool block.
//  Sits between CppSim real-valued signal paths and logic-domain consumers.
//  Passes the update toggle through so downstream blocks know new bools are valid.
// PARAMETERS
//  NCH        4     number of independent channels (>=1)
//  THRESH_HI  0.01  real; out 0->1 when value > THRESH_HI
//  THRESH_LO  0.01  real; out 1->0 when value <= THRESH_LO; require LO <= HI
//  DEBOUNCE   1     consecutive qualifying update events needed to flip (>=1)
//  INIT_OUT   0     reset value of every out bit (0/1)
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst_n       in   1        synchronous reset, active-low
//  in          in   64*NCH   packed double bits, ch k = in[64k+63:64k]
//  update_in   in   1        update toggle; any level change = one update event
//  out         out  NCH      debounced bool per channel
//  update_out  out  1        update_in delayed 1 clk (marks out valid)
//  rise        out  NCH      1-clk pulse when out[k] goes 0->1
//  fall        out  NCH      1-clk pulse when out[k] goes 1->0
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out=all INIT_OUT, rise=fall=0, cnt[k]=0,
//    upd_q<=update_in, update_out<=update_in (no spurious event after reset).
//    Reset wins over a simultaneous event; mid-debounce counts are discarded.
//  - Event: cycle where update_in != upd_q; upd_q<=update_in every clk.
//    update_in must change at most once per clk and be synchronous to clk.
//  - Per channel on event, v=$bitstoreal(slice k):
//    qualify = (out[k]==0 && v > THRESH_HI) || (out[k]==1 && v <= THRESH_LO)
//    qualify & cnt+1==DEBOUNCE -> out[k] flips, cnt=0, rise/fall[k]=1
//    qualify & cnt+1< DEBOUNCE -> cnt++; no flip
//    !qualify                  -> cnt=0 (non-consecutive resets debounce)
//  - Non-event cycles: out and cnt hold; rise=fall=0.
//  - Latency: out/rise/fall/update_out all update at the posedge ending the
//    event cycle (1 clk); update_out never leads out.
//  - cnt width $clog2(DEBOUNCE+1); never exceeds DEBOUNCE-1.
//  - NaN: both compares false -> not qualifying, holds, cnt cleared.
//    +Inf qualifies to rise; -Inf qualifies to fall; -0.0 treated as 0.0.
//  - Channels fully independent; any mix of rise/fall in the same cycle.
//  - THRESH_LO>THRESH_HI, DEBOUNCE<1 or NCH<1: $error at time 0.
//  - DEBOUNCE=1, HI=LO=0.01, NCH=1 reproduces single-channel behaviour.
// TESTING
//  1 Reset with update_in=1, INIT_OUT=0 -> out=0, update_out=1, rise=fall=0;
//    no event on first post-reset clk.
//  2 NCH=4, defaults: ch0=0.5, ch1=0.01, ch2=-1.0, ch3=0.0100001, toggle ->
//    next clk out=4'b1001, rise=4'b1001 one clk, update_out toggled.
//  3 HI=0.5, LO=0.1, ch0 events 0.3,0.6,0.3,0.1,0.2 -> out 0,1,1,0,0;
//    rise at 2nd event, fall at 4th.
//  4 DEBOUNCE=3, ch0 events 1.0,1.0,0.0,1.0,1.0,1.0 -> out rises only
//    after 6th event; rise pulses exactly once.
//  5 out[0]=1, ch0=64'h7FF8000000000000 (NaN) -> holds 1; then
//    64'hFFF0000000000000 (-Inf) -> falls; then 64'h7FF0... (+Inf) -> rises.
//  6 DEBOUNCE=3: two qualifying events, rst_n=0 one clk, then two more ->
//    no flip; third post-reset event -> flip.

Source files
------------

// File: rtl/cpp_internal_double_to_bool_hyst_array_if.sv
// Bus bundle for the multi-channel double-to-bool hysteresis converter.
interface cpp_internal_double_to_bool_hyst_array_if #(
  parameter int NCH = 4
);
  logic [64*NCH-1:0] in;
  logic              update_in;
  logic [NCH-1:0]    out;
  logic              update_out;
  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    fall;

  modport master (output in, update_in, input out, update_out, rise, fall);
  modport slave  (input in, update_in, output out, update_out, rise, fall);
endinterface

// File: rtl/cpp_internal_double_to_bool_hyst_array.sv
// Multi-channel IEEE-754 double -> bool converter with hysteresis and debounce.
// Each channel is one lane instance; the top detects update-toggle events.

module cpp_internal_double_to_bool_hyst_lane #(
  parameter logic [63:0] HI_BITS  = 64'h0,
  parameter logic [63:0] LO_BITS  = 64'h0,
  parameter int          DEBOUNCE = 1,
  parameter bit          INIT_OUT = 1'b0,
  parameter int          CW       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ev,
  input  logic [63:0] v,
  output logic        out_q,
  output logic        rise_q,
  output logic        fall_q
);
  // Map a double onto an unsigned key whose order matches numeric order.
  // Both zeros share one key so -0.0 compares equal to +0.0.
  function automatic logic [63:0] fkey(input logic [63:0] x);
    if (x[62:0] == 63'd0) fkey = 64'h8000_0000_0000_0000;
    else if (x[63])       fkey = ~x;
    else                  fkey = x | 64'h8000_0000_0000_0000;
  endfunction

  logic          is_nan, gt_hi, le_lo, qual;
  logic [CW:0]   cnt_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_d, rise_d, fall_d;

  // Threshold compares; a NaN input fails both so it never qualifies.
  always_comb begin
    is_nan  = (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
    gt_hi   = !is_nan && (fkey(v) > fkey(HI_BITS));
    le_lo   = !is_nan && !(fkey(v) > fkey(LO_BITS));
    qual    = out_q ? le_lo : gt_hi;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
  end

  // Debounce: flip after DEBOUNCE consecutive qualifying events.
  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (ev) begin
      if (!qual) begin
        cnt_d = '0;
      end else if (cnt_inc == (CW+1)'(DEBOUNCE)) begin
        out_d  = ~out_q;
        cnt_d  = '0;
        rise_d = ~out_q;
        fall_d = out_q;
      end else begin
        cnt_d = cnt_inc[CW-1:0];
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= INIT_OUT;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
endmodule

module cpp_internal_double_to_bool_hyst_array #(
  parameter int  NCH       = 4,
  parameter real THRESH_HI = 0.01,
  parameter real THRESH_LO = 0.01,
  parameter int  DEBOUNCE  = 1,
  parameter bit  INIT_OUT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  cpp_internal_double_to_bool_hyst_array_if.slave bus
);
  localparam int          CW      = $clog2(DEBOUNCE + 1);
  localparam logic [63:0] HI_BITS = $realtobits(THRESH_HI);
  localparam logic [63:0] LO_BITS = $realtobits(THRESH_LO);

  if (THRESH_LO > THRESH_HI) begin : g_bad_thresh
    $error("THRESH_LO must not exceed THRESH_HI");
  end
  if (DEBOUNCE < 1) begin : g_bad_deb
    $error("DEBOUNCE must be >= 1");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("NCH must be >= 1");
  end

  logic upd_q, upd_d, update_out_q, update_out_d, ev;

  // Any level change of the toggle is one update event.
  always_comb begin
    ev           = bus.update_in != upd_q;
    upd_d        = bus.update_in;
    update_out_d = bus.update_in;
  end

  // Reset loads the live toggle level so no event fires right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_q        <= bus.update_in;
      update_out_q <= bus.update_in;
    end else begin
      upd_q        <= upd_d;
      update_out_q <= update_out_d;
    end
  end

  assign bus.update_out = update_out_q;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    cpp_internal_double_to_bool_hyst_lane #(
      .HI_BITS (HI_BITS),
      .LO_BITS (LO_BITS),
      .DEBOUNCE(DEBOUNCE),
      .INIT_OUT(INIT_OUT),
      .CW      (CW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ev    (ev),
      .v     (bus.in[64*k +: 64]),
      .out_q (bus.out[k]),
      .rise_q(bus.rise[k]),
      .fall_q(bus.fall[k])
    );
  end
endmodule

// File: tb/tb_cpp_internal_double_to_bool_hyst_array.sv
// Bench: three configurations driven by directed vectors, checked against a
// real-arithmetic model every cycle plus hand-computed literal expectations.
module tb_cpp_internal_double_to_bool_hyst_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   miss = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  cpp_internal_double_to_bool_hyst_array_if #(.NCH(4)) if0 ();
  cpp_internal_double_to_bool_hyst_array_if #(.NCH(1)) if1 ();
  cpp_internal_double_to_bool_hyst_array_if #(.NCH(1)) if2 ();

  cpp_internal_double_to_bool_hyst_array #(.NCH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  cpp_internal_double_to_bool_hyst_array #(.NCH(1), .THRESH_HI(0.5), .THRESH_LO(0.1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  cpp_internal_double_to_bool_hyst_array #(.NCH(1), .DEBOUNCE(3)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  // ---------------- model ----------------
  real  hi_m [3] = '{0.01, 0.5, 0.01};
  real  lo_m [3] = '{0.01, 0.1, 0.01};
  int   deb_m[3] = '{1, 1, 3};
  int   nch_m[3] = '{4, 1, 1};
  logic [3:0] m_out[3], m_rise[3], m_fall[3];
  int   m_cnt[3][4];
  logic m_upd[3], m_uo[3];

  function automatic logic [63:0] d(input real r);
    return $realtobits(r);
  endfunction

  function automatic logic [63:0] g_in(input int i, input int k);
    logic [255:0] t;
    case (i)
      0:       t = if0.in;
      1:       t = {192'd0, if1.in};
      default: t = {192'd0, if2.in};
    endcase
    return t[64*k +: 64];
  endfunction

  function automatic logic g_upd(input int i);
    case (i)
      0: return if0.update_in;
      1: return if1.update_in;
      default: return if2.update_in;
    endcase
  endfunction

  function automatic logic [3:0] g_out(input int i);
    case (i)
      0: return if0.out;
      1: return {3'b0, if1.out};
      default: return {3'b0, if2.out};
    endcase
  endfunction

  function automatic logic [3:0] g_rise(input int i);
    case (i)
      0: return if0.rise;
      1: return {3'b0, if1.rise};
      default: return {3'b0, if2.rise};
    endcase
  endfunction

  function automatic logic [3:0] g_fall(input int i);
    case (i)
      0: return if0.fall;
      1: return {3'b0, if1.fall};
      default: return {3'b0, if2.fall};
    endcase
  endfunction

  function automatic logic g_uo(input int i);
    case (i)
      0: return if0.update_out;
      1: return if1.update_out;
      default: return if2.update_out;
    endcase
  endfunction

  // Model: on each update event, count consecutive qualifying samples per channel.
  always @(posedge clk) begin
    real  v;
    bit   o, q;
    logic u;
    for (int i = 0; i < 3; i++) begin
      u = g_upd(i);
      if (!rst_n) begin
        m_out[i]  <= 4'b0;
        m_rise[i] <= 4'b0;
        m_fall[i] <= 4'b0;
        for (int k = 0; k < 4; k++) m_cnt[i][k] <= 0;
      end else begin
        m_rise[i] <= 4'b0;
        m_fall[i] <= 4'b0;
        if (u != m_upd[i]) begin
          for (int k = 0; k < nch_m[i]; k++) begin
            v = $bitstoreal(g_in(i, k));
            o = m_out[i][k];
            q = o ? (v <= lo_m[i]) : (v > hi_m[i]);
            if (!q) m_cnt[i][k] <= 0;
            else if (m_cnt[i][k] + 1 >= deb_m[i]) begin
              m_cnt[i][k]  <= 0;
              m_out[i][k]  <= ~o;
              m_rise[i][k] <= ~o;
              m_fall[i][k] <= o;
            end else m_cnt[i][k] <= m_cnt[i][k] + 1;
          end
        end
      end
      m_upd[i] <= u;
      m_uo[i]  <= u;
    end
    if (!rst_n) started <= 1'b1;
  end

  // Compare DUT against the model on every falling edge once reset was seen.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (g_out(i) !== m_out[i] || g_rise(i) !== m_rise[i] ||
            g_fall(i) !== m_fall[i] || g_uo(i) !== m_uo[i]) begin
          miss++;
          $display("FAIL model inst%0d t=%0t out=%b/%b rise=%b/%b fall=%b/%b uo=%b/%b (got/exp)",
                   i, $time, g_out(i), m_out[i], g_rise(i), m_rise[i],
                   g_fall(i), m_fall[i], g_uo(i), m_uo[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev0(input logic [255:0] v);
    if0.in = v;
    if0.update_in = ~if0.update_in;
    step();
  endtask

  task automatic ev1(input real r);
    if1.in = d(r);
    if1.update_in = ~if1.update_in;
    step();
  endtask

  task automatic ev2(input real r);
    if2.in = d(r);
    if2.update_in = ~if2.update_in;
    step();
  endtask

  logic [255:0] v0;
  real seq3[5] = '{0.3, 0.6, 0.3, 0.1, 0.2};
  logic [3:0] out3[5]  = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
  logic [3:0] rise3[5] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
  logic [3:0] fall3[5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
  real seq4[6] = '{1.0, 1.0, 0.0, 1.0, 1.0, 1.0};

  initial begin
    if0.in = '0; if0.update_in = 1'b1;
    if1.in = '0; if1.update_in = 1'b0;
    if2.in = '0; if2.update_in = 1'b0;

    // 1: reset with update_in high
    repeat (2) step();
    chk("t1_out", if0.out, 4'b0000);
    chk("t1_uo", {3'b0, if0.update_out}, 4'b0001);
    chk("t1_rise", if0.rise | if0.fall, 4'b0000);
    rst_n = 1'b1;
    step();
    chk("t1_noev_out", if0.out, 4'b0000);
    chk("t1_noev_rise", if0.rise, 4'b0000);

    // 2: four channels, boundary values around 0.01
    v0 = {d(0.0100001), d(-1.0), d(0.01), d(0.5)};
    ev0(v0);
    chk("t2_out", if0.out, 4'b1001);
    chk("t2_rise", if0.rise, 4'b1001);
    chk("t2_fall", if0.fall, 4'b0000);
    chk("t2_uo", {3'b0, if0.update_out}, 4'b0000);
    step();
    chk("t2_hold_out", if0.out, 4'b1001);
    chk("t2_pulse", if0.rise, 4'b0000);

    // 5: NaN holds, -Inf falls, +Inf rises; -0.0 falls on ch3
    v0[63:0] = 64'h7FF8000000000000; ev0(v0);
    chk("t5_nan", if0.out, 4'b1001);
    v0[63:0] = 64'hFFF0000000000000; ev0(v0);
    chk("t5_ninf", if0.out, 4'b1000);
    chk("t5_ninf_fall", if0.fall, 4'b0001);
    v0[63:0] = 64'h7FF0000000000000; ev0(v0);
    chk("t5_pinf", if0.out, 4'b1001);
    chk("t5_pinf_rise", if0.rise, 4'b0001);
    v0[255:192] = 64'h8000000000000000; ev0(v0);
    chk("t5_negzero", if0.out, 4'b0001);
    chk("t5_negzero_fall", if0.fall, 4'b1000);

    // 3: hysteresis HI=0.5 LO=0.1
    for (int j = 0; j < 5; j++) begin
      ev1(seq3[j]);
      chk($sformatf("t3_out%0d", j), {3'b0, if1.out}, out3[j]);
      chk($sformatf("t3_rise%0d", j), {3'b0, if1.rise}, rise3[j]);
      chk($sformatf("t3_fall%0d", j), {3'b0, if1.fall}, fall3[j]);
    end

    // 4: debounce of 3, broken run restarts counting
    for (int j = 0; j < 6; j++) begin
      ev2(seq4[j]);
      chk($sformatf("t4_out%0d", j), {3'b0, if2.out}, (j == 5) ? 4'd1 : 4'd0);
      chk($sformatf("t4_rise%0d", j), {3'b0, if2.rise}, (j == 5) ? 4'd1 : 4'd0);
    end
    step();
    chk("t4_rise_once", {3'b0, if2.rise}, 4'd0);

    // 6: reset discards a partial debounce count
    ev2(0.0); ev2(0.0);
    chk("t6_pre", {3'b0, if2.out}, 4'd1);
    rst_n = 1'b0;
    step();
    chk("t6_rst", {3'b0, if2.out}, 4'd0);
    rst_n = 1'b1;
    step();
    ev2(1.0); ev2(1.0);
    chk("t6_noflip", {3'b0, if2.out}, 4'd0);
    ev2(1.0);
    chk("t6_flip", {3'b0, if2.out}, 4'd1);
    chk("t6_rise", {3'b0, if2.rise}, 4'd1);

    repeat (2) step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
